// File: rtl/sweep_cmd_sequencer.sv
// Sweep command sequencer: assembles little-endian UART command frames, holds one pending
// frame and issues it to the sweeper. Define SWEEP_CMD_CHECKSUM_EN for 12-byte XOR-checked frames.
module sweep_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_freq_step,
  output logic [15:0] cmd_cycles_per_step,
  output logic [31:0] cmd_init_freq,
  output logic [7:0]  cmd_mode,
  input  logic        sweep_done,
  output logic        busy,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        overrun_err
);

`ifdef SWEEP_CMD_CHECKSUM_EN
  localparam int FRAME_BYTES = 12;
`else
  localparam int FRAME_BYTES = 11;
`endif
  localparam int PAYLOAD_BYTES = 11;
  localparam int PAYLOAD_W     = 8 * PAYLOAD_BYTES;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

  // Bytes before the final one; the final byte is consumed straight from rx_data.
  logic [7:0]           byte_reg  [FRAME_BYTES-1];
  logic [7:0]           byte_next [FRAME_BYTES-1];
  logic [3:0]           idx_reg, idx_next;
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  logic                 slot_valid_reg, slot_valid_next;
  logic [PAYLOAD_W-1:0] slot_data_reg, slot_data_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 timeout_err_reg, timeout_err_next;
  logic                 overrun_err_reg, overrun_err_next;

  state_t               state_reg, state_next;
  logic                 cmd_load;
  logic [31:0]          cmd_freq_step_reg;
  logic [15:0]          cmd_cycles_per_step_reg;
  logic [31:0]          cmd_init_freq_reg;
  logic [7:0]           cmd_mode_reg;

  logic [PAYLOAD_W-1:0] payload;
  logic                 frame_done;
  logic                 frame_good;
  logic                 handshake;
  logic                 slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_BYTES - 1; gi++) begin : g_byte
      assign byte_next[gi] = (rx_valid && idx_reg == 4'(gi)) ? rx_data : byte_reg[gi];
    end
    for (gi = 0; gi < PAYLOAD_BYTES - 1; gi++) begin : g_payload
      assign payload[gi*8 +: 8] = byte_reg[gi];
    end
  endgenerate

`ifdef SWEEP_CMD_CHECKSUM_EN
  logic [7:0] chk_calc;

  always_comb begin
    chk_calc = 8'h00;
    for (int i = 0; i < FRAME_BYTES - 1; i++) begin
      chk_calc = chk_calc ^ byte_reg[i];
    end
  end

  assign payload[PAYLOAD_W-1 -: 8] = byte_reg[PAYLOAD_BYTES-1];
  // A bad mode and a bad checksum together still produce a single frame_err pulse.
  assign frame_good = (payload[PAYLOAD_W-1 -: 8] <= 8'd1) && (chk_calc == rx_data);
`else
  assign payload[PAYLOAD_W-1 -: 8] = rx_data;
  assign frame_good = (rx_data <= 8'd1);
`endif

  assign frame_done = rx_valid && (idx_reg == LAST_IDX);
  assign handshake  = cmd_valid && cmd_ready;
  assign slot_free  = !slot_valid_reg || handshake;

  // Byte index and inter-byte timeout; an arriving byte always beats an expiry.
  always_comb begin
    idx_next         = idx_reg;
    cnt_next         = cnt_reg;
    timeout_err_next = 1'b0;
    if (rx_valid) begin
      cnt_next = '0;
      idx_next = frame_done ? 4'd0 : idx_reg + 4'd1;
    end else if (idx_reg != 4'd0) begin
      if (cnt_reg == TIMEOUT_LAST) begin
        idx_next         = 4'd0;
        cnt_next         = '0;
        timeout_err_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Pending slot: a slot vacated by this cycle's handshake can take the new frame at once.
  always_comb begin
    slot_valid_next  = slot_valid_reg;
    slot_data_next   = slot_data_reg;
    frame_err_next   = 1'b0;
    overrun_err_next = 1'b0;
    if (handshake) begin
      slot_valid_next = 1'b0;
    end
    if (frame_done) begin
      if (!frame_good) begin
        frame_err_next = 1'b1;
      end else if (slot_free) begin
        slot_valid_next = 1'b1;
        slot_data_next  = payload;
      end else begin
        overrun_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg         <= '0;
      cnt_reg         <= '0;
      slot_valid_reg  <= 1'b0;
      slot_data_reg   <= '0;
      frame_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
      for (int i = 0; i < FRAME_BYTES - 1; i++) begin
        byte_reg[i] <= 8'h00;
      end
    end else begin
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      slot_valid_reg  <= slot_valid_next;
      slot_data_reg   <= slot_data_next;
      frame_err_reg   <= frame_err_next;
      timeout_err_reg <= timeout_err_next;
      overrun_err_reg <= overrun_err_next;
      byte_reg        <= byte_next;
    end
  end

  // Dispatcher; sweep_done outside WAIT_DONE is stale and ignored.
  always_comb begin
    state_next = state_reg;
    cmd_load   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (slot_valid_reg) begin
          state_next = ST_ISSUE;
          cmd_load   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_next = (cmd_mode_reg == 8'd0) ? ST_WAIT_DONE : ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (sweep_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg               <= ST_IDLE;
      cmd_freq_step_reg       <= '0;
      cmd_cycles_per_step_reg <= '0;
      cmd_init_freq_reg       <= '0;
      cmd_mode_reg            <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_load) begin
        cmd_freq_step_reg       <= slot_data_reg[31:0];
        cmd_cycles_per_step_reg <= slot_data_reg[47:32];
        cmd_init_freq_reg       <= slot_data_reg[79:48];
        cmd_mode_reg            <= slot_data_reg[87:80];
      end
    end
  end

  assign cmd_valid           = (state_reg == ST_ISSUE);
  assign cmd_freq_step       = cmd_freq_step_reg;
  assign cmd_cycles_per_step = cmd_cycles_per_step_reg;
  assign cmd_init_freq       = cmd_init_freq_reg;
  assign cmd_mode            = cmd_mode_reg;
  assign busy                = slot_valid_reg || (state_reg != ST_IDLE);
  assign frame_err           = frame_err_reg;
  assign timeout_err         = timeout_err_reg;
  assign overrun_err         = overrun_err_reg;

endmodule

// File: doc/sweep_cmd_sequencer.md
Name: sweep_cmd_sequencer

Overview:
- Sits between the UART RX byte stream and the frequency sweeper.
- Assembles 11-byte little-endian command frames, validates the mode byte, and holds one completed frame in a pending slot.
- Issues the frame to the sweeper over a valid/ready handshake, then blocks further issue until a sweep command reports sweep_done.
- Recovers from stalled or partial frames with an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles allowed between bytes of one frame (1 ms at 50 MHz).
- TIMEOUT_W, 16, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received UART byte.
- cmd_valid  out  1  command presented to the sweeper.
- cmd_ready  in  1  sweeper accepts the command this cycle.
- cmd_freq_step  out  32  frame bytes 0-3.
- cmd_cycles_per_step  out  16  frame bytes 4-5.
- cmd_init_freq  out  32  frame bytes 6-9.
- cmd_mode  out  8  frame byte 10; 0 = sweep, 1 = PLL.
- sweep_done  in  1  sweeper completion pulse.
- busy  out  1  pending slot occupied or dispatcher not in IDLE.
- frame_err  out  1  one-cycle pulse: mode byte > 1, frame dropped.
- timeout_err  out  1  one-cycle pulse: partial frame discarded.
- overrun_err  out  1  one-cycle pulse: frame completed while pending slot full, new frame dropped.

Behaviour:
- Reset: every output is 0. Byte index = 0, timeout counter = 0, pending slot empty, dispatcher in IDLE.

Assembler (independent of the dispatcher):
- On rx_valid, write rx_data into byte[idx] (bit field idx*8), then idx++.
- The timeout counter clears on every rx_valid. It increments each cycle while idx != 0.
- At idx == 10, an accepted byte completes the frame and idx returns to 0.
- Mode byte > 1: the frame is discarded and frame_err pulses on the cycle after the last byte.
- Otherwise the frame is loaded into the pending slot on the next cycle.
- Pending slot full at completion: the new frame is dropped and overrun_err pulses.
  - Exception: if the slot is vacated in the same cycle (handshake completes), the new frame loads and there is no overrun.
- Timeout: the counter reaching TIMEOUT_CYCLES with idx != 0 sets idx = 0, clears the counter and pulses timeout_err.
  - rx_valid in the expiry cycle wins: the byte is accepted and there is no timeout.
- No timeout while idx == 0.

Dispatcher FSM (IDLE, ISSUE, WAIT_DONE):
- IDLE: if the pending slot is valid, drive the cmd_* fields from the slot and go to ISSUE. cmd_valid rises the cycle after the slot loads (latency: last rx_valid to cmd_valid = 2 cycles).
- ISSUE: cmd_valid = 1 and cmd_* stay stable until cmd_ready.
  - On cmd_valid & cmd_ready: the pending slot frees and cmd_valid drops next cycle.
  - Next state is WAIT_DONE if mode = 0, else IDLE.
  - sweep_done seen in ISSUE is ignored as stale.
- WAIT_DONE: remain until sweep_done, then go to IDLE. The next pending frame issues no earlier than the cycle after.
- cmd_* fields hold their last issued value outside ISSUE.
- reset at any point returns to the reset state. Partial and pending frames are lost and no error pulse is generated.

Optional Feature:
- Macro: SWEEP_CMD_CHECKSUM_EN.
- Defined:
  - Frame is 12 bytes; byte 11 is the XOR of bytes 0-10.
  - On mismatch the frame is dropped and frame_err pulses; a mode check failure pulses frame_err once.
  - Timeout applies to idx 1-11.
- Undefined: frame is 11 bytes and no checksum logic is present.

Test Plan:
- Bytes FF,00,00,00,64,00,FF,FF,00,00,00 with cmd_ready = 1 -> cmd_valid 2 cycles after the last byte with freq_step = 0x000000FF, cycles = 100, init_freq = 0x0000FFFF, mode = 0. State goes to WAIT_DONE; busy = 1 until 1 cycle after sweep_done.
- PLL frame (init byte 0x80, mode 01) sent during WAIT_DONE of a sweep -> held pending with cmd_valid = 0. It issues the cycle after sweep_done; after cmd_ready the FSM returns to IDLE directly.
- 5 bytes then silence -> timeout_err pulses exactly TIMEOUT_CYCLES after the 5th byte. A following complete valid frame decodes correctly.
- Mode byte 0x02 -> frame_err pulse, cmd_valid stays 0, busy stays 0.
- cmd_ready held 0 with one frame pending and a second frame completed -> overrun_err pulse, first frame still presented unchanged. With cmd_ready and frame completion in the same cycle -> no overrun.
- reset asserted at byte 7 of a frame and during ISSUE -> all outputs 0 next cycle. A subsequent full frame issues normally.
